conv135_window_sequencer: RTL and testbench

Sequencing controller for the 135° grouped-coefficient convolution datapath. It holds the five Gabor coefficients for the current run and drives them to the datapath. It accepts 5x5 pixel windows from the line-buffer window generator under a valid/ready handshake and registers the five grouped products returned by the datapath. It sums the products into one filter response and emits that response, tagged with its output-pixel coordinates, under a second valid/ready handshake, while counting windows and signalling frame completion.

---
 rtl/conv135_window_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_conv135_window_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv135_window_sequencer.sv
// -----------------------------------------------------------------------------
// conv135_window_sequencer
//
// Sequencing controller for the 135-degree grouped-coefficient convolution
// datapath. Holds the five Gabor coefficients for a run and drives them to the
// datapath, accepts 5x5 windows from the line-buffer window generator, captures
// the five grouped products the datapath returns for each accepted window,
// sums them into one filter response and emits it tagged with its output-pixel
// coordinates. Frame progress is tracked with row/column tag counters and a
// one-cycle done pulse marks the end of a frame.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   cfg_we/addr/data       coefficient write port (honoured in IDLE only,
//                          addresses 5..7 ignored)
//   coeff1..coeff5         registered coefficients to the datapath
//   start, abort           frame start; synchronous frame abandon (abort wins)
//   busy, done             busy in RUN/DRAIN; one-cycle end-of-frame pulse
//   win_valid/win_ready    window handshake from the window generator
//   prod1..prod5           datapath products for the presented window (same cycle)
//   out_valid/out_ready    response handshake to downstream
//   out_data               signed sum of the five products
//   out_row, out_col       0-based output-pixel coordinates of out_data
//   dbg_state              FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds valid and its payload
// stable until that edge; ready may depend combinationally on this block's
// registered state and on out_ready, never on win_valid.
// -----------------------------------------------------------------------------
module conv135_window_sequencer #(
    parameter int IMG_WIDTH   = 516,
    parameter int IMG_HEIGHT  = 516,
    parameter int KERNEL_SIZE = 5,
    parameter int COEFF_W     = 17,
    parameter int PROD_W      = 26,
    parameter int SUM_W       = 29
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [COEFF_W-1:0] cfg_data,
    output logic [COEFF_W-1:0] coeff1,
    output logic [COEFF_W-1:0] coeff2,
    output logic [COEFF_W-1:0] coeff3,
    output logic [COEFF_W-1:0] coeff4,
    output logic [COEFF_W-1:0] coeff5,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    input  logic               win_valid,
    output logic               win_ready,
    input  logic [PROD_W-1:0]  prod1,
    input  logic [PROD_W-1:0]  prod2,
    input  logic [PROD_W-1:0]  prod3,
    input  logic [PROD_W-1:0]  prod4,
    input  logic [PROD_W-1:0]  prod5,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SUM_W-1:0]   out_data,
    output logic [15:0]        out_row,
    output logic [15:0]        out_col,
    output logic [1:0]         dbg_state
);

    localparam int OW = IMG_WIDTH - KERNEL_SIZE + 1;
    localparam int OH = IMG_HEIGHT - KERNEL_SIZE + 1;
    localparam logic [15:0] LAST_COL = 16'(OW - 1);
    localparam logic [15:0] LAST_ROW = 16'(OH - 1);
    localparam int EXT_W = SUM_W - PROD_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   busy_q, done_q;
    logic [15:0] row_q, col_q;

    logic [COEFF_W-1:0] coeff1_q, coeff2_q, coeff3_q, coeff4_q, coeff5_q;

    logic               s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0]  s1_prod_q [5];
    logic [15:0]        s1_row_q, s1_col_q;

    logic               s2_valid_q, s2_valid_d;
    logic [SUM_W-1:0]   out_data_q;
    logic [15:0]        out_row_q, out_col_q;

    logic               s1_advance;
    logic               win_accept;
    logic               last_window;
    logic [SUM_W-1:0]   s1_sum;

    // S1 may hand its contents to S2 whenever S2 is empty or being drained.
    assign s1_advance  = ~s2_valid_q | out_ready;
    assign win_ready   = (state_q == ST_RUN) & (~s1_valid_q | s1_advance);
    assign win_accept  = win_valid & win_ready;
    assign last_window = (row_q == LAST_ROW) & (col_q == LAST_COL);

    // Pipeline occupancy for the next cycle. An accept refills S1 in the same
    // cycle it empties into S2; abort flushes both stages.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            s1_valid_d = 1'b0;
        end
        if (win_accept) begin
            s1_valid_d = 1'b1;
        end
        if (abort) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (win_accept && last_window) state_d = ST_DRAIN;
            // Leaves on the edge where the final response handshakes.
            ST_DRAIN: if (!s1_valid_d && !s2_valid_d) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // FSM, registered status outputs and the output-pixel tag counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            row_q   <= 16'd0;
            col_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done_q  <= (state_d == ST_DONE);
            if (abort || (state_q == ST_IDLE && start)) begin
                row_q <= 16'd0;
                col_q <= 16'd0;
            end else if (win_accept) begin
                if (col_q == LAST_COL) begin
                    col_q <= 16'd0;
                    row_q <= (row_q == LAST_ROW) ? 16'd0 : row_q + 16'd1;
                end else begin
                    col_q <= col_q + 16'd1;
                end
            end
        end
    end

    // Coefficients only change between frames; abort leaves them intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coeff1_q <= '0;
            coeff2_q <= '0;
            coeff3_q <= '0;
            coeff4_q <= '0;
            coeff5_q <= '0;
        end else if (cfg_we && state_q == ST_IDLE) begin
            case (cfg_addr)
                3'd0:    coeff1_q <= cfg_data;
                3'd1:    coeff2_q <= cfg_data;
                3'd2:    coeff3_q <= cfg_data;
                3'd3:    coeff4_q <= cfg_data;
                3'd4:    coeff5_q <= cfg_data;
                default: ;
            endcase
        end
    end

    // Sign-extended sum of the S1 products; three guard bits cover 5 terms.
    always_comb begin
        s1_sum = '0;
        for (int i = 0; i < 5; i++) begin
            s1_sum = s1_sum + {{EXT_W{s1_prod_q[i][PROD_W-1]}}, s1_prod_q[i]};
        end
    end

    // Two-stage datapath: S1 captures products and tag, S2 holds the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                s1_prod_q[i] <= '0;
            end
            s1_row_q   <= 16'd0;
            s1_col_q   <= 16'd0;
            out_data_q <= '0;
            out_row_q  <= 16'd0;
            out_col_q  <= 16'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (win_accept) begin
                s1_prod_q[0] <= prod1;
                s1_prod_q[1] <= prod2;
                s1_prod_q[2] <= prod3;
                s1_prod_q[3] <= prod4;
                s1_prod_q[4] <= prod5;
                s1_row_q     <= row_q;
                s1_col_q     <= col_q;
            end
            if (s1_valid_q && s1_advance) begin
                out_data_q <= s1_sum;
                out_row_q  <= s1_row_q;
                out_col_q  <= s1_col_q;
            end
        end
    end

    assign coeff1    = coeff1_q;
    assign coeff2    = coeff2_q;
    assign coeff3    = coeff3_q;
    assign coeff4    = coeff4_q;
    assign coeff5    = coeff5_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv135_window_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for conv135_window_sequencer on an 8x6 image (4x2 output frame, 8
// windows). A push process records the expected response for every window
// handshake; a monitor process pops and compares on every response handshake.
// -----------------------------------------------------------------------------
module tb_conv135_window_sequencer;

    localparam int IMG_WIDTH   = 8;
    localparam int IMG_HEIGHT  = 6;
    localparam int KERNEL_SIZE = 5;
    localparam int COEFF_W     = 17;
    localparam int PROD_W      = 26;
    localparam int SUM_W       = 29;
    localparam int OW          = IMG_WIDTH - KERNEL_SIZE + 1;
    localparam int OH          = IMG_HEIGHT - KERNEL_SIZE + 1;
    localparam int N           = OW * OH;
    localparam int EW          = SUM_W + 32;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic rst;
    logic cfg_we;
    logic [2:0] cfg_addr;
    logic [COEFF_W-1:0] cfg_data;
    logic [COEFF_W-1:0] coeff1, coeff2, coeff3, coeff4, coeff5;
    logic start, abort, busy, done;
    logic win_valid, win_ready;
    logic [PROD_W-1:0] prod1, prod2, prod3, prod4, prod5;
    logic out_valid, out_ready;
    logic [SUM_W-1:0] out_data;
    logic [15:0] out_row, out_col;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    conv135_window_sequencer #(
        .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .KERNEL_SIZE(KERNEL_SIZE),
        .COEFF_W(COEFF_W), .PROD_W(PROD_W), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .coeff1(coeff1), .coeff2(coeff2), .coeff3(coeff3), .coeff4(coeff4), .coeff5(coeff5),
        .start(start), .abort(abort), .busy(busy), .done(done),
        .win_valid(win_valid), .win_ready(win_ready),
        .prod1(prod1), .prod2(prod2), .prod3(prod3), .prod4(prod4), .prod5(prod5),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp    = 0;
    int n_fail   = 0;
    int k_model  = 0;
    int done_cnt = 0;
    int resp_cnt = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: k-th window of a frame lands at (k / OW, k % OW); the
    // response is the plain signed sum of the five products.
    always @(negedge clk) begin
        logic signed [63:0] s;
        if (rst || abort) begin
            exp_q.delete();
            k_model = 0;
        end else begin
            if (start && !busy) k_model = 0;
            if (win_valid && win_ready) begin
                s = longint'($signed(prod1)) + longint'($signed(prod2)) + longint'($signed(prod3))
                  + longint'($signed(prod4)) + longint'($signed(prod5));
                exp_q.push_back({s[SUM_W-1:0], 16'(k_model / OW), 16'(k_model % OW)});
                k_model++;
            end
        end
    end

    // Monitor: compare every response handshake against the queue head.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (done) done_cnt++;
        if (!rst && out_valid && out_ready) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_response", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", longint'(out_data), longint'(e[EW-1:32]));
                check("out_row", longint'(out_row), longint'(e[31:16]));
                check("out_col", longint'(out_col), longint'(e[15:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [COEFF_W-1:0] coeff_at(input int i);
        case (i)
            0: return coeff1;
            1: return coeff2;
            2: return coeff3;
            3: return coeff4;
            default: return coeff5;
        endcase
    endfunction

    task automatic cfg_write(input logic [2:0] a, input logic [COEFF_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // pmode 0: fixed 1..5, 1: random, 2: all products at one extreme.
    task automatic gen_prods(input int pmode);
        logic [PROD_W-1:0] v;
        case (pmode)
            0: begin prod1 = 1; prod2 = 2; prod3 = 3; prod4 = 4; prod5 = 5; end
            1: begin
                prod1 = PROD_W'($urandom); prod2 = PROD_W'($urandom); prod3 = PROD_W'($urandom);
                prod4 = PROD_W'($urandom); prod5 = PROD_W'($urandom);
            end
            default: begin
                v = ($urandom_range(1) == 1) ? {1'b1, {(PROD_W-1){1'b0}}} : {1'b0, {(PROD_W-1){1'b1}}};
                prod1 = v; prod2 = v; prod3 = v; prod4 = v; prod5 = v;
            end
        endcase
    endtask

    // Streams n windows; optionally forces out_ready low for 5 cycles once
    // stall_at windows have been accepted, with win_valid held high.
    task automatic run_frame(input int n, input int valid_pct, input bit rand_ready,
                             input int stall_at, input int pmode);
        int sent = 0;
        int cyc = 0;
        int stall = -1;
        bit pres = 1'b0;
        while (sent < n && cyc < 2000) begin
            if (stall < 0 && stall_at >= 0 && sent == stall_at) stall = 0;
            if (stall >= 0 && stall < 5) out_ready = 1'b0;
            else out_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
            if (!pres && ((stall >= 0 && stall < 5) || $urandom_range(99) < valid_pct)) begin
                pres = 1'b1;
                gen_prods(pmode);
            end
            win_valid = pres;
            @(negedge clk);
            if (stall >= 2 && stall < 5) check("win_ready_stalled", win_ready, 0);
            if (pres && win_ready) begin
                sent++;
                pres = 1'b0;
            end
            if (stall >= 0 && stall < 5) stall++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("frame_windows_sent", sent, n);
        win_valid = 1'b0;
    endtask

    task automatic wait_done(input int done0, input int resp0);
        int cyc = 0;
        bit seen = 1'b0;
        win_valid = 1'b0;
        out_ready = 1'b1;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check("busy_at_done", busy, 0);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("queue_empty", exp_q.size(), 0);
        check("frame_responses", resp_cnt - resp0, N);
        step();
        check("done_pulses", done_cnt - done0, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [COEFF_W-1:0] cexp [5];
        logic [COEFF_W-1:0] c3_old;
        int d0, r0, sent, cyc;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = '0;
        start = 1'b0; abort = 1'b0; win_valid = 1'b0; out_ready = 1'b1;
        prod1 = '0; prod2 = '0; prod3 = '0; prod4 = '0; prod5 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) check("reset_coeff", coeff_at(i), 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_win_ready", win_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_row", out_row, 0);
        check("reset_out_col", out_col, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Coefficient load, plus an ignored out-of-range address.
        for (int i = 0; i < 5; i++) begin
            cexp[i] = COEFF_W'($urandom);
            cfg_write(3'(i), cexp[i]);
        end
        cfg_write(3'd5, 17'h1FFFF);
        for (int i = 0; i < 5; i++) check("coeff_load", coeff_at(i), cexp[i]);

        // Frame 1: fixed products, full throughput, win_valid ignored in IDLE.
        win_valid = 1'b1;
        @(negedge clk);
        check("idle_win_ready", win_ready, 0);
        step();
        win_valid = 1'b0;
        d0 = done_cnt; r0 = resp_cnt;
        do_start();
        check("busy_in_run", busy, 1);
        run_frame(N, 100, 1'b0, -1, 0);
        wait_done(d0, r0);

        // Frame 2: start with a simultaneous coefficient write, random
        // products and backpressure, plus a forced 5-cycle stall.
        cexp[0] = COEFF_W'($urandom);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = cexp[0]; start = 1'b1;
        d0 = done_cnt; r0 = resp_cnt;
        step();
        cfg_we = 1'b0; start = 1'b0;
        check("start_cfg_coeff1", coeff1, cexp[0]);
        check("start_cfg_busy", busy, 1);
        run_frame(N, 70, 1'b1, 3, 1);
        wait_done(d0, r0);

        // Frame 3: extreme products; a coefficient write during RUN is dropped.
        c3_old = coeff3;
        d0 = done_cnt; r0 = resp_cnt;
        do_start();
        cfg_write(3'd2, 17'h1ABCD);
        check("run_cfg_dropped", coeff3, c3_old);
        run_frame(N, 100, 1'b1, -1, 2);
        wait_done(d0, r0);
        check("coeff3_after_frame", coeff3, c3_old);
        cfg_write(3'd2, 17'h1ABCD);
        check("coeff3_post_done", coeff3, 17'h1ABCD);

        // Abort after 3 accepted windows with both stages full.
        d0 = done_cnt;
        do_start();
        sent = 0; cyc = 0;
        out_ready = 1'b1;
        gen_prods(1);
        win_valid = 1'b1;
        while (sent < 3 && cyc < 50) begin
            @(negedge clk);
            if (win_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
            if (sent < 3) gen_prods(1);
        end
        check("abort_windows_sent", sent, 3);
        win_valid = 1'b0; out_ready = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_win_ready", win_ready, 0);
        check("abort_coeff3", coeff3, 17'h1ABCD);
        repeat (5) step();
        check("abort_no_done", done_cnt - d0, 0);

        // Fresh frame after abort: tags restart at (0,0).
        d0 = done_cnt; r0 = resp_cnt;
        do_start();
        run_frame(N, 80, 1'b1, -1, 1);
        wait_done(d0, r0);

        // Asynchronous reset with both pipeline stages full.
        do_start();
        out_ready = 1'b0;
        gen_prods(1);
        win_valid = 1'b1;
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) check("rst_coeff", coeff_at(i), 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_win_ready", win_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_col", out_col, 0);
        win_valid = 1'b0;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
